imem_load_arbiter: RTL and testbench
====================================

IMEM_LOAD_ARBITER -- requirements
Module: imem_load_arbiter

Interface
REQ-001 SHALL have parameter INSTR_W, default 8, giving the instruction word width.
REQ-002 SHALL have parameter DEPTH, default 16, giving the instruction store depth; the address is 4 bits wide.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port host_valid, input, 1 bit: the host presents a load beat.
REQ-006 SHALL have port host_ready, output, 1 bit: the block accepts a load beat this cycle.
REQ-007 SHALL have port host_addr, input, 4 bits: target word address of the beat.
REQ-008 SHALL have port host_data, input, INSTR_W bits: instruction word of the beat.
REQ-009 SHALL have port host_last, input, 1 bit: the beat is the final beat of the program.
REQ-010 SHALL have port start, input, 1 bit: single-cycle request to run the CPU.
REQ-011 SHALL have port stop, input, 1 bit: single-cycle request to halt the CPU.
REQ-012 SHALL have port cpu_addr, input, 4 bits: CPU fetch address (instruction_addr).
REQ-013 SHALL have port cpu_instr, output, INSTR_W bits: instruction word returned to the CPU.
REQ-014 SHALL have port cpu_reset, output, 1 bit: drives the CPU reset; high holds the CPU.
REQ-015 SHALL have port state_out, output, 2 bits: current state (IDLE=0, LOAD=1, RUN=2).
REQ-016 SHALL have port load_count, output, 5 bits: beats accepted since the last load began.
REQ-017 SHALL have port loaded, output, 1 bit: a complete program (host_last accepted) is resident.

Function
REQ-018 SHALL hold a DEPTH x INSTR_W register store; a beat is accepted when host_valid && host_ready.
REQ-019 SHALL write an accepted beat's host_data into mem[host_addr] on that clock edge; a later beat to the same address overwrites the earlier one.
REQ-020 SHALL drive host_ready=1 in IDLE and LOAD, and host_ready=0 in RUN.
REQ-021 SHALL, in IDLE, on an accepted beat: write it, set load_count=1, clear loaded; go to LOAD if host_last=0, or stay in IDLE with loaded=1 if host_last=1.
REQ-022 SHALL, in LOAD, on each accepted beat: increment load_count, saturating at 16; on a beat with host_last=1, go to IDLE and set loaded=1.
REQ-023 SHALL ignore start and stop while in LOAD.
REQ-024 SHALL, in IDLE with start=1, loaded=1 and no accepted beat, go to RUN on the next edge.
REQ-025 SHALL, in IDLE, give an accepted beat priority over start: the start is dropped, not queued.
REQ-026 SHALL ignore start in IDLE when loaded=0.
REQ-027 SHALL drive cpu_reset=1 in IDLE and LOAD, and cpu_reset=0 only in RUN.
REQ-028 SHALL make cpu_reset rise in the same cycle that state_out leaves RUN.
REQ-029 SHALL, in RUN, drive cpu_instr = mem[cpu_addr] combinationally (zero-latency read), matching the CPU's single-cycle fetch expectation.
REQ-030 SHALL drive cpu_instr to all zeros outside RUN.
REQ-031 SHALL, in RUN, return to IDLE on stop=1; loaded and the memory contents are retained, so a later start reruns the same program from CPU reset.
REQ-032 SHALL, in RUN, treat simultaneous start and stop as stop.
REQ-033 SHALL ignore host_valid in RUN: no write, no counter change.

Reset
REQ-034 SHALL, on reset assertion (asynchronous, any state including mid-load or RUN), immediately force state=IDLE, cpu_reset=1, host_ready=1, cpu_instr=0, load_count=0, loaded=0, and clear all memory words to 0.
REQ-035 SHALL resume normal operation on the first rising clk edge after reset deasserts.

Verification
REQ-036 SHALL pass: after reset, load 3 beats (addr 0..2, data 8'h11, 8'h22, 8'h33, host_last on 3rd) -> load_count=3, loaded=1, state=IDLE, cpu_reset=1.
REQ-037 SHALL pass: start pulse, then cpu_addr=1 -> next cycle state=RUN, cpu_reset=0, cpu_instr=8'h22; host_valid during RUN gives host_ready=0 and mem unchanged.
REQ-038 SHALL pass: start before any load -> state stays IDLE, cpu_reset=1; start in the same cycle as an accepted beat -> beat written, no RUN.
REQ-039 SHALL pass: start and stop together in RUN -> IDLE next cycle; a second start -> RUN with the same program intact.
REQ-040 SHALL pass: reset asserted asynchronously mid-LOAD after 2 beats -> outputs clear without a clock edge, loaded=0, and mem[0]=0 after reset.
REQ-041 SHALL pass: 18 beats in one load, with addr wrapping 0..15 then 0..1 -> load_count saturates at 16, and mem[0] and mem[1] hold the last-written values.

Source files
------------

// File: rtl/imem_load_arbiter.sv
// Instruction-memory load arbiter: the host streams a program into a register store,
// then the CPU is released from reset and fetches from that store until halted.
module imem_load_arbiter #(
    parameter int INSTR_W = 8,
    parameter int DEPTH   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               host_valid,
    output logic               host_ready,
    input  logic [3:0]         host_addr,
    input  logic [INSTR_W-1:0] host_data,
    input  logic               host_last,
    input  logic               start,
    input  logic               stop,
    input  logic [3:0]         cpu_addr,
    output logic [INSTR_W-1:0] cpu_instr,
    output logic               cpu_reset,
    output logic [1:0]         state_out,
    output logic [4:0]         load_count,
    output logic               loaded
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam logic [4:0] CNT_MAX = 5'd16;

    state_e                          state_q, state_d;
    logic [4:0]                      cnt_q, cnt_d;
    logic                            loaded_q, loaded_d;
    logic [DEPTH-1:0][INSTR_W-1:0]   mem_q;
    logic                            beat;

    // Accept only outside RUN; a beat in RUN is invisible to every register.
    assign host_ready = (state_q != RUN);
    assign beat       = host_valid && host_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        loaded_d = loaded_q;
        case (state_q)
            IDLE: begin
                // A beat starts a new load and wins over start, which is dropped.
                if (beat) begin
                    cnt_d    = 5'd1;
                    loaded_d = host_last;
                    state_d  = host_last ? IDLE : LOAD;
                end else if (start && loaded_q) begin
                    state_d = RUN;
                end
            end
            LOAD: begin
                if (beat) begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 5'd1;
                    if (host_last) begin
                        loaded_d = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            RUN: begin
                if (stop) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            loaded_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            loaded_q <= loaded_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (beat) begin
            mem_q[host_addr] <= host_data;
        end
    end

    // cpu_reset and cpu_instr decode straight from the state register so they follow
    // an asynchronous reset with no clock and rise in the cycle RUN is left.
    assign cpu_reset  = (state_q != RUN);
    assign cpu_instr  = (state_q == RUN) ? mem_q[cpu_addr] : '0;
    assign state_out  = state_q;
    assign load_count = cnt_q;
    assign loaded     = loaded_q;

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Directed bench for imem_load_arbiter: load, run, stop, reset and saturation scenarios.
module tb_imem_load_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       host_valid;
    logic       host_ready;
    logic [3:0] host_addr;
    logic [7:0] host_data;
    logic       host_last;
    logic       start;
    logic       stop;
    logic [3:0] cpu_addr;
    logic [7:0] cpu_instr;
    logic       cpu_reset;
    logic [1:0] state_out;
    logic [4:0] load_count;
    logic       loaded;

    int total = 0;
    int bad   = 0;

    imem_load_arbiter #(.INSTR_W(8), .DEPTH(16)) dut (
        .clk(clk), .reset(reset),
        .host_valid(host_valid), .host_ready(host_ready), .host_addr(host_addr),
        .host_data(host_data), .host_last(host_last),
        .start(start), .stop(stop),
        .cpu_addr(cpu_addr), .cpu_instr(cpu_instr), .cpu_reset(cpu_reset),
        .state_out(state_out), .load_count(load_count), .loaded(loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and land 1 time unit after it, clear of the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [3:0] a, input logic [7:0] d, input logic l);
        host_valid = 1'b1;
        host_addr  = a;
        host_data  = d;
        host_last  = l;
        tick();
        host_valid = 1'b0;
        host_last  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #3 reset = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; host_valid = 1'b0; host_addr = '0; host_data = '0;
        host_last = 1'b0; start = 1'b0; stop = 1'b0; cpu_addr = '0;
        #12;
        chk("rst_state", state_out, 2'd0);
        chk("rst_cpu_reset", cpu_reset, 1'b1);
        chk("rst_host_ready", host_ready, 1'b1);
        chk("rst_count", load_count, 5'd0);
        chk("rst_loaded", loaded, 1'b0);
        chk("rst_instr", cpu_instr, 8'h00);
        reset = 1'b0;
        tick();

        // Start before any program is resident is ignored
        pulse_start();
        chk("start_unloaded_state", state_out, 2'd0);
        chk("start_unloaded_cpu_reset", cpu_reset, 1'b1);

        // Three-beat load
        beat(4'd0, 8'h11, 1'b0);
        chk("load1_state", state_out, 2'd1);
        chk("load1_count", load_count, 5'd1);
        pulse_start();
        chk("load_start_ignored", state_out, 2'd1);
        beat(4'd1, 8'h22, 1'b0);
        beat(4'd2, 8'h33, 1'b1);
        chk("load3_count", load_count, 5'd3);
        chk("load3_loaded", loaded, 1'b1);
        chk("load3_state", state_out, 2'd0);
        chk("load3_cpu_reset", cpu_reset, 1'b1);
        chk("idle_instr_zero", cpu_instr, 8'h00);

        // Run and fetch
        pulse_start();
        chk("run_state", state_out, 2'd2);
        chk("run_cpu_reset", cpu_reset, 1'b0);
        cpu_addr = 4'd1; #1;
        chk("run_fetch1", cpu_instr, 8'h22);
        host_valid = 1'b1; host_addr = 4'd1; host_data = 8'hFF; #1;
        chk("run_host_ready", host_ready, 1'b0);
        tick();
        host_valid = 1'b0;
        chk("run_ignore_count", load_count, 5'd3);
        chk("run_mem_unchanged", cpu_instr, 8'h22);
        cpu_addr = 4'd2; #1;
        chk("run_fetch2", cpu_instr, 8'h33);

        // Stop returns to IDLE and reasserts CPU reset in the same cycle
        pulse_stop();
        chk("stop_state", state_out, 2'd0);
        chk("stop_cpu_reset", cpu_reset, 1'b1);
        chk("stop_instr_zero", cpu_instr, 8'h00);
        chk("stop_loaded_kept", loaded, 1'b1);

        // Simultaneous start/stop in RUN behaves as stop; rerun keeps program
        pulse_start();
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("startstop_state", state_out, 2'd0);
        pulse_start();
        chk("rerun_state", state_out, 2'd2);
        cpu_addr = 4'd0; #1;
        chk("rerun_fetch0", cpu_instr, 8'h11);
        pulse_stop();

        // Beat wins over start in IDLE
        start = 1'b1;
        beat(4'd4, 8'h44, 1'b1);
        start = 1'b0;
        chk("beat_prio_state", state_out, 2'd0);
        chk("beat_prio_count", load_count, 5'd1);
        chk("beat_prio_loaded", loaded, 1'b1);
        pulse_start();
        cpu_addr = 4'd4; #1;
        chk("beat_prio_written", cpu_instr, 8'h44);
        pulse_stop();

        // Async reset mid-LOAD clears outputs without a clock edge
        beat(4'd0, 8'hAA, 1'b0);
        beat(4'd1, 8'hBB, 1'b0);
        chk("mid_load_count", load_count, 5'd2);
        #2 reset = 1'b1;
        #1;
        chk("async_state", state_out, 2'd0);
        chk("async_count", load_count, 5'd0);
        chk("async_loaded", loaded, 1'b0);
        chk("async_cpu_reset", cpu_reset, 1'b1);
        chk("async_host_ready", host_ready, 1'b1);
        #2 reset = 1'b0;
        tick();
        beat(4'd5, 8'h55, 1'b1);
        pulse_start();
        cpu_addr = 4'd0; #1;
        chk("async_mem0_cleared", cpu_instr, 8'h00);
        cpu_addr = 4'd5; #1;
        chk("async_mem5", cpu_instr, 8'h55);
        pulse_stop();

        // 18-beat load with address wrap: count saturates at 16
        for (int i = 0; i < 18; i++) begin
            beat(4'(i % 16), 8'(8'h80 + i), (i == 17));
            if (i == 15) chk("sat_count16", load_count, 5'd16);
        end
        chk("sat_count18", load_count, 5'd16);
        chk("sat_loaded", loaded, 1'b1);
        pulse_start();
        cpu_addr = 4'd0; #1;
        chk("sat_mem0", cpu_instr, 8'h90);
        cpu_addr = 4'd1; #1;
        chk("sat_mem1", cpu_instr, 8'h91);
        cpu_addr = 4'd2; #1;
        chk("sat_mem2", cpu_instr, 8'h82);
        cpu_addr = 4'd15; #1;
        chk("sat_mem15", cpu_instr, 8'h8F);

        // Reset while in RUN
        do_reset();
        chk("run_reset_state", state_out, 2'd0);
        chk("run_reset_instr", cpu_instr, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
